// File: rtl/counter_driver.sv
// counter_driver: client-side sequencer for one Counter instance.
// Accepts a job of N back-to-back runs, fires startSignal once per run when the
// Counter is ready, totals busy-high cycles, and guards each run with a watchdog.
module counter_driver #(
  parameter int unsigned MAX_AMOUNT = 22,
  parameter int unsigned SLACK      = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TOT_W      = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run__ENA,
  input  logic [CNT_W-1:0] run_count,
  output logic             run__RDY,
  output logic             done__ENA,
  input  logic             done__RDY,
  output logic [TOT_W-1:0] done_cycles,
  output logic             done_error,
  output logic             active,
  output logic             startSignal__ENA,
  input  logic             startSignal__RDY,
  input  logic             busy,
  input  logic             busy__RDY
);

  localparam int unsigned LIMIT = MAX_AMOUNT + SLACK;
  localparam int unsigned TMR_W = $clog2(LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    RUN,
    REPORT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [TOT_W-1:0]   total;
  logic               errFlag;
  logic [TMR_W-1:0]   timer;

  logic [TMR_W-1:0]   timerNext;
  logic [TOT_W-1:0]   totalInc;
  logic               trip;
  logic               busyValid;

  // Handshake outputs and per-cycle helper values.
  always_comb begin
    run__RDY         = (state == IDLE);
    active           = (state != IDLE);
    done__ENA        = (state == REPORT) && done__RDY;
    startSignal__ENA = (state == ISSUE) && startSignal__RDY && busy__RDY;
    done_cycles      = total;
    done_error       = errFlag;
    timerNext        = timer + 1'b1;
    totalInc         = (total == '1) ? total : total + 1'b1;
    // The watchdog trips on the cycle the timer would reach the limit; that
    // cycle's busy sample is not added to the total.
    trip             = (timerNext == TMR_W'(LIMIT));
    busyValid        = busy && busy__RDY;
  end

  // Job sequencer: state, run counter, busy total, error flag and run timer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      remaining <= '0;
      total     <= '0;
      errFlag   <= 1'b0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run__ENA) begin
            total   <= '0;
            errFlag <= 1'b0;
            if (run_count != '0) begin
              remaining <= run_count;
              state     <= ISSUE;
            end else begin
              state <= REPORT;
            end
          end
        end
        ISSUE: begin
          if (startSignal__ENA) begin
            timer <= '0;
            state <= ARM;
          end
        end
        ARM: begin
          timer <= timerNext;
          if (trip) begin
            errFlag <= 1'b1;
            state   <= REPORT;
          end else if (busyValid) begin
            total <= totalInc;
            state <= RUN;
          end
        end
        RUN: begin
          timer <= timerNext;
          if (trip) begin
            errFlag <= 1'b1;
            state   <= REPORT;
          end else if (busy__RDY) begin
            if (busy) begin
              total <= totalInc;
            end else begin
              remaining <= remaining - 1'b1;
              state     <= (remaining == CNT_W'(1)) ? REPORT : ISSUE;
            end
          end
        end
        REPORT: begin
          if (done__ENA) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// Testbench for counter_driver: a behavioural Counter model plus directed and
// randomized jobs, with expected totals computed from per-job arithmetic.
module tb_counter_driver;

  localparam int MAXA  = 22;
  localparam int SLK   = 8;
  localparam int CNT_W = 8;
  localparam int TOT_W = 24;

  logic             CLK = 1'b0;
  logic             RST;
  logic             run__ENA;
  logic [CNT_W-1:0] run_count;
  logic             run__RDY;
  logic             done__ENA;
  logic             done__RDY;
  logic [TOT_W-1:0] done_cycles;
  logic             done_error;
  logic             active;
  logic             startSignal__ENA;
  logic             startSignal__RDY;
  logic             busy;
  logic             busy__RDY;

  int nChecks = 0;
  int nFails  = 0;

  // Counter model state
  logic cBusy;
  int   cLeft;
  int   startsSeen;
  int   hangRun;
  logic startLow;

  always #5 CLK = ~CLK;

  counter_driver #(
    .MAX_AMOUNT(MAXA),
    .SLACK     (SLK),
    .CNT_W     (CNT_W),
    .TOT_W     (TOT_W)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .run__ENA        (run__ENA),
    .run_count       (run_count),
    .run__RDY        (run__RDY),
    .done__ENA       (done__ENA),
    .done__RDY       (done__RDY),
    .done_cycles     (done_cycles),
    .done_error      (done_error),
    .active          (active),
    .startSignal__ENA(startSignal__ENA),
    .startSignal__RDY(startSignal__RDY),
    .busy            (busy),
    .busy__RDY       (busy__RDY)
  );

  assign busy             = cBusy;
  assign startSignal__RDY = !cBusy && !startLow;

  // Conforming Counter: busy for MAXA valid cycles after each start; the hung
  // run keeps busy high indefinitely.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cBusy <= 1'b0;
      cLeft <= 0;
    end else if (startSignal__ENA) begin
      cBusy <= 1'b1;
      cLeft <= MAXA;
    end else if (cBusy && busy__RDY && !(hangRun != 0 && startsSeen == hangRun)) begin
      if (cLeft == 1) cBusy <= 1'b0;
      cLeft <= cLeft - 1;
    end
  end

  task automatic checkVal(input string tag, input longint got, input longint exp);
    nChecks++;
    if (got != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, ":run__RDY"},         run__RDY, 1);
    checkVal({tag, ":done__ENA"},        done__ENA, 0);
    checkVal({tag, ":startSignal__ENA"}, startSignal__ENA, 0);
    checkVal({tag, ":active"},           active, 0);
    checkVal({tag, ":done_cycles"},      done_cycles, 0);
    checkVal({tag, ":done_error"},       done_error, 0);
  endtask

  // dropMode: 0 none, 1 random busy__RDY drops (max 3 per run), 2 drops in cycles 20..22
  task automatic runJob(input string tag, input int count, input int hang, input int stLow,
                        input int hold, input int dropMode, input int expLat);
    int  cyc;
    int  drops;
    int  w;
    int  expTot;
    int  expErr;
    int  expStarts;
    bit  seen;
    expTot    = (hang != 0) ? MAXA * (hang - 1) + (MAXA + SLK - 1) : MAXA * count;
    expErr    = (hang != 0) ? 1 : 0;
    expStarts = (hang != 0) ? hang : count;

    // let a previously hung Counter drain before the next job
    hangRun   = 0;
    busy__RDY = 1'b1;
    startLow  = 1'b0;
    done__RDY = 1'b0;
    w = 0;
    while (cBusy && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (cBusy) checkVal({tag, ":drainTimeout"}, 0, 1);

    @(negedge CLK);
    #1;
    checkVal({tag, ":rdyBeforeJob"}, run__RDY, 1);
    hangRun    = hang;
    startsSeen = 0;
    drops      = 0;
    run__ENA   = 1'b1;
    run_count  = CNT_W'(count);
    @(posedge CLK);
    #1;
    run__ENA  = 1'b0;
    run_count = CNT_W'($urandom);

    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      startLow  = (cyc <= stLow);
      done__RDY = (cyc > hold);
      busy__RDY = 1'b1;
      if (cBusy && !(hang != 0 && startsSeen == hang)) begin
        if (dropMode == 1 && drops < 3 && $urandom_range(7) == 0) begin
          busy__RDY = 1'b0;
          drops++;
        end
        if (dropMode == 2 && cyc >= 20 && cyc <= 22) busy__RDY = 1'b0;
      end
      #1;
      if (startSignal__ENA) begin
        startsSeen++;
        drops = 0;
        checkVal({tag, ":startHasRdy"}, startSignal__RDY && busy__RDY, 1);
      end
      if (done__ENA) begin
        seen = 1'b1;
        checkVal({tag, ":doneHasRdy"},  done__RDY, 1);
        checkVal({tag, ":done_cycles"}, done_cycles, expTot);
        checkVal({tag, ":done_error"},  done_error, expErr);
        checkVal({tag, ":starts"},      startsSeen, expStarts);
        checkVal({tag, ":activeAtDone"}, active, 1);
        if (expLat >= 0) checkVal({tag, ":latency"}, cyc, expLat);
      end else begin
        checkVal({tag, ":rdyWhileBusy"}, run__RDY, 0);
      end
    end
    if (!seen) checkVal({tag, ":doneTimeout"}, 0, 1);

    @(negedge CLK);
    done__RDY = 1'b0;
    #1;
    checkVal({tag, ":rdyAfterDone"},    run__RDY, 1);
    checkVal({tag, ":activeAfterDone"}, active, 0);
  endtask

  initial begin
    RST       = 1'b1;
    run__ENA  = 1'b0;
    run_count = '0;
    done__RDY = 1'b1;
    busy__RDY = 1'b1;
    startLow  = 1'b0;
    hangRun   = 0;
    startsSeen = 0;
    repeat (3) @(negedge CLK);
    #1;
    checkIdleOutputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    done__RDY = 1'b0;

    runJob("oneRun",   1, 0, 0,  0, 0, MAXA + 3);
    runJob("threeRun", 3, 0, 0,  0, 0, 3 * (MAXA + 2) + 1);
    runJob("zeroRun",  0, 0, 0,  0, 0, 1);
    runJob("watchdog", 2, 2, 0,  0, 0, (MAXA + 2) + 2 + (MAXA + SLK));
    runJob("stalls",   1, 0, 10, 0, 2, MAXA + 3 + 10 + 3);

    // reset in the middle of a five-run job
    @(negedge CLK);
    run__ENA  = 1'b1;
    run_count = CNT_W'(5);
    @(posedge CLK);
    #1;
    run__ENA = 1'b0;
    repeat (40) @(negedge CLK);
    RST       = 1'b1;
    done__RDY = 1'b1;
    #1;
    checkIdleOutputs("midReset");
    @(negedge CLK);
    RST = 1'b0;
    done__RDY = 1'b0;
    runJob("afterReset", 1, 0, 0, MAXA + 7, 0, MAXA + 7 + 1);

    for (int j = 0; j < 30; j++) begin
      int cnt;
      int hng;
      cnt = $urandom_range(5);
      hng = (cnt > 0 && $urandom_range(3) == 0) ? $urandom_range(cnt, 1) : 0;
      runJob($sformatf("rand%0d", j), cnt, hng, $urandom_range(3),
             $urandom_range(cnt * 26 + 30), 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
